// File: rtl/master_port.sv
// Serial bus master: turns a parallel command plus write/read words into a config frame and bit-serial data.
// Latency: CL config cycles, then a ready handshake, then DATA_WIDTH cycles per word; rdata lands 1 cycle after the final sample.
// Backpressure: cmd_ready only in IDLE; wdata is pulled one word at a time; read sampling stalls while ready=0.
module master_port #(
    parameter int ADDR_DEPTH = 2000,
    parameter int SLAVES     = 3,
    parameter int DATA_WIDTH = 32,
    parameter int S_ID_WIDTH = $clog2(SLAVES + 1),
    parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH),
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [S_ID_WIDTH-1:0] cmd_slave_id,
    input  logic                  cmd_write,
    input  logic                  cmd_burst,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  done,
    output logic                  control,
    output logic                  wD,
    output logic                  valid,
    output logic                  last,
    input  logic                  rD,
    input  logic                  ready
);

    localparam int CL      = 5 + S_ID_WIDTH + ADDR_WIDTH;
    localparam int CNT_MAX = (CL > DATA_WIDTH) ? CL : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CFG_LAST = CNT_W'(CL - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LEN_WIDTH:0] WORD_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        WAIT_RDY,
        WLOAD,
        WRITE,
        READ,
        FIN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CL-1:0]         cfg_sr;
    logic [DATA_WIDTH-1:0] data_sr;
    logic [CNT_W-1:0]      bit_cnt;
    logic [LEN_WIDTH:0]    word_cnt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  write_q;

    logic bit_end;
    logic final_word;

    assign bit_end    = (bit_cnt == BIT_LAST);
    // len_q is already forced to 0 for single-word commands, so one compare covers both modes
    assign final_word = (word_cnt == {1'b0, len_q});

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        control     = 1'b0;
        wD          = 1'b0;
        valid       = 1'b0;
        last        = 1'b0;
        wdata_ready = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_nxt = CONFIG;
                end
            end
            CONFIG: begin
                control = cfg_sr[CL-1];
                if (bit_cnt == CFG_LAST) begin
                    state_nxt = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (ready) begin
                    state_nxt = write_q ? WLOAD : READ;
                end
            end
            WLOAD: begin
                if (wdata_valid) begin
                    wdata_ready = 1'b1;
                    state_nxt   = WRITE;
                end
            end
            WRITE: begin
                valid = 1'b1;
                wD    = data_sr[DATA_WIDTH-1];
                last  = bit_end && final_word;
                if (bit_end) begin
                    state_nxt = final_word ? FIN : WLOAD;
                end
            end
            READ: begin
                last = ready && bit_end && final_word;
                if (ready && bit_end && final_word) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cfg_sr      <= '0;
            data_sr     <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            len_q       <= '0;
            write_q     <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        // frame: sync 111, slave id, write flag, burst flag, start address
                        cfg_sr   <= {3'b111, cmd_slave_id, cmd_write, cmd_burst, cmd_addr};
                        write_q  <= cmd_write;
                        len_q    <= cmd_burst ? cmd_len : '0;
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end
                end
                CONFIG: begin
                    cfg_sr  <= {cfg_sr[CL-2:0], 1'b0};
                    bit_cnt <= (bit_cnt == CFG_LAST) ? '0 : bit_cnt + CNT_ONE;
                end
                WLOAD: begin
                    if (wdata_valid) begin
                        data_sr <= wdata;
                        bit_cnt <= '0;
                    end
                end
                WRITE: begin
                    data_sr <= {data_sr[DATA_WIDTH-2:0], 1'b0};
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (!final_word) begin
                            word_cnt <= word_cnt + WORD_ONE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
                READ: begin
                    if (ready) begin
                        data_sr <= {data_sr[DATA_WIDTH-2:0], rD};
                        if (bit_end) begin
                            bit_cnt     <= '0;
                            rdata       <= {data_sr[DATA_WIDTH-2:0], rD};
                            rdata_valid <= 1'b1;
                            if (!final_word) begin
                                word_cnt <= word_cnt + WORD_ONE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
